// File: rtl/gate_response_checker.sv
// Gate response checker: latches each applied {a,b}, waits SETTLE_CYC cycles,
// compares the seven observed gate outputs and keeps error/coverage results.
module gate_response_checker #(
  parameter int SETTLE_CYC = 2,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             a,
  input  logic             b,
  input  logic             vld,
  input  logic             y1_and,
  input  logic             y2_or,
  input  logic             y3_nand,
  input  logic             y4_nor,
  input  logic             y5_xor,
  input  logic             y6_xnor,
  input  logic             y7_not,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       seen,
  output logic             ovr,
  output logic [8:0]       fail_vec
);

  typedef enum logic [2:0] {IDLE, ARMED, SETTLE, CHECK, DONE} state_t;

  localparam int         CNT_INIT_I = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;
  localparam logic [3:0] CNT_INIT   = CNT_INIT_I[3:0];

  state_t             state_reg, state_next;
  logic [3:0]         cnt_reg, cnt_next;
  logic [1:0]         ab_reg, ab_next;
  logic [ERR_W-1:0]   err_reg, err_next;
  logic [3:0]         seen_reg, seen_next;
  logic               ovr_reg, ovr_next;
  logic [8:0]         fail_reg, fail_next;

  logic [6:0] exp_y;
  logic [6:0] obs_y;
  logic [3:0] seen_upd;

  // Expected responses come from the latched stimulus, never the live a/b.
  always_comb begin
    exp_y = {ab_reg[1] & ab_reg[0], ab_reg[1] | ab_reg[0],
             ~(ab_reg[1] & ab_reg[0]), ~(ab_reg[1] | ab_reg[0]),
             ab_reg[1] ^ ab_reg[0], ~(ab_reg[1] ^ ab_reg[0]), ~ab_reg[1]};
    obs_y = {y1_and, y2_or, y3_nand, y4_nor, y5_xor, y6_xnor, y7_not};
    seen_upd = seen_reg | (4'b0001 << ab_reg);
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ab_next    = ab_reg;
    err_next   = err_reg;
    seen_next  = seen_reg;
    ovr_next   = ovr_reg;
    fail_next  = fail_reg;

    case (state_reg)
      IDLE: ;
      ARMED: begin
        if (vld) begin
          ab_next = {a, b};
          if (SETTLE_CYC == 0) begin
            state_next = CHECK;
          end else begin
            state_next = SETTLE;
            cnt_next   = CNT_INIT;
          end
        end
      end
      SETTLE: begin
        if (vld) ovr_next = 1'b1;
        if (cnt_reg == 4'd0) state_next = CHECK;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      CHECK: begin
        if (vld) ovr_next = 1'b1;
        if (obs_y != exp_y) begin
          // A zero count means no mismatch yet in this run: saturation never wraps.
          if (err_reg == '0) fail_next = {ab_reg, obs_y};
          if (err_reg != '1) err_next  = err_reg + ERR_W'(1);
        end
        seen_next  = seen_upd;
        state_next = (seen_upd == 4'b1111) ? DONE : ARMED;
      end
      DONE: ;
      default: state_next = IDLE;
    endcase

    if (start) begin
      state_next = ARMED;
      cnt_next   = 4'd0;
      err_next   = '0;
      seen_next  = 4'd0;
      ovr_next   = 1'b0;
      fail_next  = 9'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      ab_reg    <= 2'd0;
      err_reg   <= '0;
      seen_reg  <= 4'd0;
      ovr_reg   <= 1'b0;
      fail_reg  <= 9'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ab_reg    <= ab_next;
      err_reg   <= err_next;
      seen_reg  <= seen_next;
      ovr_reg   <= ovr_next;
      fail_reg  <= fail_next;
    end
  end

  assign busy     = (state_reg == ARMED) || (state_reg == SETTLE) || (state_reg == CHECK);
  assign done     = (state_reg == DONE);
  assign pass     = done && (err_reg == '0) && !ovr_reg;
  assign err_cnt  = err_reg;
  assign seen     = seen_reg;
  assign ovr      = ovr_reg;
  assign fail_vec = fail_reg;

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: two instances (default and SETTLE_CYC=0/ERR_W=2)
// checked every cycle against a timestamp-based model, plus literal scenario checks.
module tb_gate_response_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, a, b, vld;
  logic [6:0] y;

  logic       busy0, done0, pass0, ovr0;
  logic [7:0] err0;
  logic [3:0] seen0;
  logic [8:0] fail0;
  logic       busy1, done1, pass1, ovr1;
  logic [1:0] err1;
  logic [3:0] seen1;
  logic [8:0] fail1;

  gate_response_checker #(.SETTLE_CYC(2), .ERR_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .vld(vld),
    .y1_and(y[6]), .y2_or(y[5]), .y3_nand(y[4]), .y4_nor(y[3]),
    .y5_xor(y[2]), .y6_xnor(y[1]), .y7_not(y[0]),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
    .seen(seen0), .ovr(ovr0), .fail_vec(fail0));

  gate_response_checker #(.SETTLE_CYC(0), .ERR_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .vld(vld),
    .y1_and(y[6]), .y2_or(y[5]), .y3_nand(y[4]), .y4_nor(y[3]),
    .y5_xor(y[2]), .y6_xnor(y[1]), .y7_not(y[0]),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .seen(seen1), .ovr(ovr1), .fail_vec(fail1));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] corr(input logic [1:0] ab);
    logic x, z;
    x = ab[1];
    z = ab[0];
    return {x & z, x | z, ~(x & z), ~(x | z), x ^ z, ~(x ^ z), ~x};
  endfunction

  // Model: a run is a mode plus the absolute edge number at which the pending sample is judged.
  localparam int MI = 0, MA = 1, MW = 2, MD = 3;
  int m_settle[2] = '{2, 0};
  int m_emax[2]   = '{255, 3};
  int m_mode[2], m_err[2], m_seen[2], m_ovr[2], m_fv[2], m_at[2], m_ab[2], m_hadf[2];
  int cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0;
      for (int k = 0; k < 2; k++) begin
        m_mode[k] = MI; m_err[k] = 0; m_seen[k] = 0; m_ovr[k] = 0;
        m_fv[k] = 0; m_at[k] = 0; m_ab[k] = 0; m_hadf[k] = 0;
      end
    end else begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (start) begin
          m_mode[k] = MA; m_err[k] = 0; m_seen[k] = 0; m_ovr[k] = 0;
          m_fv[k] = 0; m_hadf[k] = 0;
        end else if (m_mode[k] == MA) begin
          if (vld) begin
            m_ab[k]   = {30'd0, a, b};
            m_at[k]   = cyc + m_settle[k] + 1;
            m_mode[k] = MW;
          end
        end else if (m_mode[k] == MW) begin
          if (vld) m_ovr[k] = 1;
          if (cyc == m_at[k]) begin
            if (y != corr(m_ab[k][1:0])) begin
              if (!m_hadf[k]) m_fv[k] = m_ab[k] * 128 + y;
              m_hadf[k] = 1;
              if (m_err[k] < m_emax[k]) m_err[k]++;
            end
            m_seen[k] = m_seen[k] | (1 << m_ab[k]);
            m_mode[k] = (m_seen[k] == 15) ? MD : MA;
          end
        end
      end
    end
  end

  string onm[7] = '{"busy", "done", "pass", "err_cnt", "seen", "ovr", "fail_vec"};

  always @(negedge clk) begin
    int act[7];
    int ex[7];
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (k == 0) act = '{busy0, done0, pass0, err0, seen0, ovr0, fail0};
        else        act = '{busy1, done1, pass1, err1, seen1, ovr1, fail1};
        ex[0] = (m_mode[k] == MA || m_mode[k] == MW) ? 1 : 0;
        ex[1] = (m_mode[k] == MD) ? 1 : 0;
        ex[2] = (m_mode[k] == MD && m_err[k] == 0 && m_ovr[k] == 0) ? 1 : 0;
        ex[3] = m_err[k];
        ex[4] = m_seen[k];
        ex[5] = m_ovr[k];
        ex[6] = m_fv[k];
        for (int i = 0; i < 7; i++) chk($sformatf("model_d%0d_%s", k, onm[i]), act[i], ex[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [1:0] ab, input logic [6:0] yv);
    {a, b} = ab;
    y      = yv;
    vld    = 1'b1;
    tick();
    vld = 1'b0;
    repeat (3) tick();
  endtask

  logic [1:0] ab_r;

  initial begin
    rst_n = 1'b0; start = 1'b0; vld = 1'b0; a = 1'b0; b = 1'b0; y = 7'd0;
    #12;
    chk("rst_busy", busy0, 0);   chk("rst_done", done0, 0);  chk("rst_pass", pass0, 0);
    chk("rst_err", err0, 0);     chk("rst_seen", seen0, 0);  chk("rst_ovr", ovr0, 0);
    chk("rst_fail", fail0, 0);
    rst_n = 1'b1;
    tick();

    // All four vectors correct: done and pass three cycles after the fourth vld
    do_start();
    send(2'b00, corr(2'b00));
    send(2'b01, corr(2'b01));
    send(2'b10, corr(2'b10));
    {a, b} = 2'b11; y = corr(2'b11); vld = 1'b1;
    tick();
    vld = 1'b0;
    tick(); tick();
    chk("s1_done_early", done0, 0);
    tick();
    chk("s1_done", done0, 1);  chk("s1_pass", pass0, 1);
    chk("s1_err", err0, 0);    chk("s1_seen", seen0, 15);

    // One bad vector
    do_start();
    send(2'b00, corr(2'b00));
    send(2'b01, corr(2'b01));
    send(2'b11, corr(2'b11));
    send(2'b10, 7'b0110011);
    chk("s2_done", done0, 1);  chk("s2_err", err0, 1);
    chk("s2_fail", fail0, 9'b10_0110011);  chk("s2_pass", pass0, 0);

    // Back-to-back vld: second one is an overrun and never checked
    do_start();
    {a, b} = 2'b00; y = corr(2'b00); vld = 1'b1;
    tick();
    {a, b} = 2'b01; y = corr(2'b01);
    tick();
    vld = 1'b0;
    repeat (3) tick();
    chk("s3_ovr", ovr0, 1);  chk("s3_seen", seen0, 1);  chk("s3_busy", busy0, 1);

    // Reset pulse mid-settle clears immediately; vld ignored afterwards
    do_start();
    {a, b} = 2'b11; y = corr(2'b11); vld = 1'b1;
    tick();
    vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("s4_busy", busy0, 0);  chk("s4_ovr", ovr0, 0);  chk("s4_seen", seen0, 0);
    chk("s4_busy1", busy1, 0); chk("s4_seen1", seen1, 0);
    #2 rst_n = 1'b1;
    send(2'b10, corr(2'b10));
    chk("s4_idle_busy", busy0, 0);  chk("s4_idle_seen", seen0, 0);  chk("s4_idle_done", done0, 0);

    // Error saturation on the 2-bit counter
    do_start();
    send(2'b00, ~corr(2'b00));
    send(2'b00, ~corr(2'b00));
    send(2'b01, ~corr(2'b01));
    send(2'b10, ~corr(2'b10));
    send(2'b11, ~corr(2'b11));
    chk("s5_err1_sat", err1, 3);  chk("s5_err0", err0, 5);
    chk("s5_fail1", fail1, 9'b00_1100100);  chk("s5_done1", done1, 1);

    // Zero settle: check lands one cycle after vld
    do_start();
    {a, b} = 2'b10; y = corr(2'b10); vld = 1'b1;
    tick();
    vld = 1'b0;
    chk("s6_seen1_pre", seen1, 0);
    tick();
    chk("s6_seen1", seen1, 4);  chk("s6_seen0", seen0, 0);

    // Randomized traffic checked by the model
    do_start();
    repeat (1500) begin
      start = ($urandom_range(0, 79) == 0);
      vld   = ($urandom_range(0, 2) == 0);
      if (vld) begin
        ab_r   = 2'($urandom_range(0, 3));
        {a, b} = ab_r;
        y = corr(ab_r) ^ (($urandom_range(0, 4) == 0) ? (7'b0000001 << $urandom_range(0, 6)) : 7'd0);
      end
      tick();
    end
    start = 1'b0;
    vld   = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
